updown_count_monitor: RTL and testbench

UPDOWN_COUNT_MONITOR -- requirements
Module: updown_count_monitor

---
 rtl/updown_count_monitor_if.sv | 25 ++
 rtl/updown_count_monitor.sv | 104 ++++++++++
 tb/tb_updown_count_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/updown_count_monitor_if.sv
// Bus between a counter observer and updown_count_monitor.
// master drives samples and err_clr; slave returns direction, wrap and lap.
interface updown_count_monitor_if #(
    parameter int WIDTH = 4,
    parameter int LAP_W = 8
);
    logic             sample_en;
    logic [WIDTH-1:0] count_in;
    logic             err_clr;
    logic             dir_valid;
    logic             dir_up;
    logic             wrap_pulse;
    logic [LAP_W-1:0] lap_count;
    logic             err;

    modport master (
        output sample_en, count_in, err_clr,
        input  dir_valid, dir_up, wrap_pulse, lap_count, err
    );

    modport slave (
        input  sample_en, count_in, err_clr,
        output dir_valid, dir_up, wrap_pulse, lap_count, err
    );
endinterface

// File: rtl/updown_count_monitor.sv
// Watches an up/down counter: tracks direction, counts wraps, flags bad steps.
// Ports: clk, reset (async, active-low), bus (slave: sample_en/count_in/err_clr in; dir_valid/dir_up/wrap_pulse/lap_count/err out).
module updown_count_monitor #(
    parameter int WIDTH = 4,
    parameter int LAP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    updown_count_monitor_if.slave  bus
);
    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT,
        S_UP,
        S_DOWN,
        S_FAULT
    } state_t;

    localparam logic [WIDTH-1:0] D_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] D_ZERO  = '0;
    localparam logic [WIDTH-1:0] D_MAX   = '1;
    localparam logic [LAP_W-1:0] LAP_ONE = {{(LAP_W-1){1'b0}}, 1'b1};
    localparam logic [LAP_W-1:0] LAP_MAX = {1'b0, {(LAP_W-1){1'b1}}};
    localparam logic [LAP_W-1:0] LAP_MIN = {1'b1, {(LAP_W-1){1'b0}}};

    state_t           state_q, state_n;
    logic [WIDTH-1:0] prev_q, prev_n;
    logic [LAP_W-1:0] lap_q, lap_n;
    logic             err_q, err_n;
    logic             wrap_q, wrap_n;
    logic [WIDTH-1:0] delta;

    assign delta = bus.count_in - prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            prev_q  <= '0;
            lap_q   <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            prev_q  <= prev_n;
            lap_q   <= lap_n;
            err_q   <= err_n;
            wrap_q  <= wrap_n;
        end
    end

    always_comb begin
        state_n = state_q;
        prev_n  = prev_q;
        lap_n   = lap_q;
        err_n   = err_q;
        wrap_n  = 1'b0;
        if (bus.err_clr) begin
            // re-arm wins over any sample in the same cycle
            state_n = S_INIT;
            err_n   = 1'b0;
        end else if (bus.sample_en) begin
            unique case (state_q)
                S_INIT: begin
                    prev_n  = bus.count_in;
                    state_n = S_WAIT;
                end
                S_WAIT, S_UP, S_DOWN: begin
                    prev_n = bus.count_in;
                    unique case (1'b1)
                        (delta == D_ZERO): ;
                        (delta == D_ONE): begin
                            state_n = S_UP;
                            if (prev_q == D_MAX) begin
                                wrap_n = 1'b1;
                                if (lap_q != LAP_MAX)
                                    lap_n = lap_q + LAP_ONE;
                            end
                        end
                        (delta == D_MAX): begin
                            state_n = S_DOWN;
                            if (prev_q == D_ZERO) begin
                                wrap_n = 1'b1;
                                if (lap_q != LAP_MIN)
                                    lap_n = lap_q - LAP_ONE;
                            end
                        end
                        default: begin
                            state_n = S_FAULT;
                            err_n   = 1'b1;
                            prev_n  = prev_q;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.dir_valid  = (state_q == S_UP) || (state_q == S_DOWN);
    assign bus.dir_up     = (state_q == S_UP);
    assign bus.wrap_pulse = wrap_q;
    assign bus.lap_count  = lap_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench for updown_count_monitor.
// Hand-computed expectations for direction, wrap, lap, fault and reset.
module tb_updown_count_monitor;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    updown_count_monitor_if #(.WIDTH(4), .LAP_W(8)) bus ();

    updown_count_monitor #(.WIDTH(4), .LAP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [3:0] v,
                        input logic clr);
        bus.sample_en = en;
        bus.count_in  = v;
        bus.err_clr   = clr;
        @(posedge clk);
        #1;
        bus.sample_en = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic outs(input string tag, input logic dv, input logic du,
                        input logic wp, input logic [7:0] lap,
                        input logic e);
        chk({tag, ".dv"}, 32'(bus.dir_valid), 32'(dv));
        chk({tag, ".du"}, 32'(bus.dir_up), 32'(du));
        chk({tag, ".wp"}, 32'(bus.wrap_pulse), 32'(wp));
        chk({tag, ".lap"}, 32'(bus.lap_count), 32'(lap));
        chk({tag, ".err"}, 32'(bus.err), 32'(e));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int exp_lap;
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.sample_en = 1'b0;
        bus.count_in  = '0;
        bus.err_clr   = 1'b0;
        #2 reset = 1'b0;
        #1 outs("rst", 0, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // 3,4,5: direction after second sample
        step(1, 4'h3, 0); outs("s3", 0, 0, 0, 8'h00, 0);
        step(1, 4'h4, 0); outs("s4", 1, 1, 0, 8'h00, 0);
        step(1, 4'h5, 0); outs("s5", 1, 1, 0, 8'h00, 0);

        // up wrap E,F,0,1
        step(0, 4'h0, 1); outs("clr1", 0, 0, 0, 8'h00, 0);
        step(1, 4'hE, 0);
        step(1, 4'hF, 0); outs("uF", 1, 1, 0, 8'h00, 0);
        step(1, 4'h0, 0); outs("u0", 1, 1, 1, 8'h01, 0);
        step(1, 4'h1, 0); outs("u1", 1, 1, 0, 8'h01, 0);
        // err_clr with a sample keeps lap
        step(1, 4'h7, 1); outs("clr2", 0, 0, 0, 8'h01, 0);

        // down wrap 1,0,F,E from clean reset
        do_reset();
        outs("rst2", 0, 0, 0, 8'h00, 0);
        step(1, 4'h1, 0);
        step(1, 4'h0, 0); outs("d0", 1, 0, 0, 8'h00, 0);
        step(1, 4'hF, 0); outs("dF", 1, 0, 1, 8'hFF, 0);
        step(1, 4'hE, 0); outs("dE", 1, 0, 0, 8'hFF, 0);
        // reversal is legal
        step(1, 4'hF, 0); outs("rev", 1, 1, 0, 8'hFF, 0);

        // stall, idle, then illegal jump
        do_reset();
        step(1, 4'h4, 0);
        step(1, 4'h5, 0); outs("st5", 1, 1, 0, 8'h00, 0);
        step(1, 4'h5, 0); outs("st55", 1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 4'hC, 0);
            outs("idle", 1, 1, 0, 8'h00, 0);
        end
        step(1, 4'h6, 0); outs("st6", 1, 1, 0, 8'h00, 0);
        step(1, 4'h9, 0); outs("flt", 0, 0, 0, 8'h00, 1);
        step(1, 4'hA, 0); outs("fltA", 0, 0, 0, 8'h00, 1);
        step(1, 4'h7, 1); outs("fclr", 0, 0, 0, 8'h00, 0);
        // 7 was discarded: 8 is an INIT load, 9 gives UP
        step(1, 4'h8, 0); outs("i8", 0, 0, 0, 8'h00, 0);
        step(1, 4'h9, 0); outs("i9", 1, 1, 0, 8'h00, 0);

        // 130 up-wraps, saturating at 127
        do_reset();
        step(1, 4'h0, 0);
        for (int k = 1; k <= 130; k++) begin
            for (int v = 1; v <= 15; v++)
                step(1, 4'(v), 0);
            step(1, 4'h0, 0);
            exp_lap = (k > 127) ? 127 : k;
            chk("sat.wp", 32'(bus.wrap_pulse), 32'd1);
            chk("sat.lap", 32'(bus.lap_count), 32'(exp_lap));
        end

        // async reset mid-stream, pending sample discarded
        bus.sample_en = 1'b1;
        bus.count_in  = 4'h1;
        #1 reset = 1'b0;
        #1 outs("arst", 0, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1 outs("arst2", 0, 0, 0, 8'h00, 0);
        reset = 1'b1;
        bus.sample_en = 1'b0;
        step(1, 4'h5, 0); outs("post5", 0, 0, 0, 8'h00, 0);
        step(1, 4'h6, 0); outs("post6", 1, 1, 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
